// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the run-length encoded word stream, used by the
// encoder, the capture buffer (rle_buffer) and the host-side decoder model.
//   Word format: bit 15 = 0 -> sample word, counts as one original sample.
//                bit 15 = 1 -> extra-repeat count in bits [14:0].
// No ports (package).
// ---------------------------------------------------------------------------
package rle_pkg;

  localparam int          RLE_FLAG_BIT = 15;
  localparam int          RLE_CNT_MSB  = 14;
  localparam logic [15:0] RLE_OVF_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rle_state_t;

  // Number of original samples an encoded word stands for.
  function automatic logic [15:0] rle_weight(input logic [15:0] word);
    rle_weight = word[RLE_FLAG_BIT] ? {1'b0, word[RLE_CNT_MSB:0]} : 16'd1;
  endfunction

endpackage

// File: rtl/rle_fifo.sv
// ---------------------------------------------------------------------------
// rle_fifo
// Synchronous first-word fall-through FIFO, 2^ADDR_W words of DATA_W bits.
// Optional macro RLE_LEVEL_EN adds registered o_level / o_almost_full.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_flush         empty the FIFO (has priority over read/write)
//   i_wr, i_wdata   write request and data (dropped when full without a read)
//   i_rd            read request (ignored while empty)
//   o_rdata         head word (0 while empty)
//   o_empty, o_full status derived from the pointers
//   o_level         [RLE_LEVEL_EN] word count
//   o_almost_full   [RLE_LEVEL_EN] level >= 2^ADDR_W - 8
// ---------------------------------------------------------------------------
module rle_fifo
  import rle_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
`ifdef RLE_LEVEL_EN
  ,
  output logic [ADDR_W:0]   o_level,
  output logic              o_almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_empty;
  logic              w_full;
  logic              w_rd;
  logic              w_wr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_rd    = i_rd & ~w_empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign w_wr    = i_wr & (~w_full | w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

`ifdef RLE_LEVEL_EN
  logic [ADDR_W:0] r_level;
  logic            r_almost_full;
  logic [ADDR_W:0] w_level_nxt;

  always_comb begin
    w_level_nxt = r_level;
    if (i_flush)          w_level_nxt = '0;
    else if (w_wr && !w_rd) w_level_nxt = r_level + 1'b1;
    else if (w_rd && !w_wr) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= (ADDR_W+1)'(DEPTH - 8));
    end
  end

  assign o_level       = r_level;
  assign o_almost_full = r_almost_full;
`endif

endmodule

// File: rtl/rle_buffer.sv
// ---------------------------------------------------------------------------
// rle_buffer
// Buffers the run-length encoded word stream in a FWFT FIFO, counts the
// original samples it represents and ends the capture at the programmed
// depth, then drains the FIFO to the memory writer.
// Optional macro RLE_LEVEL_EN adds fifo_level / almost_full ports.
// Ports:
//   core_clk, core_rst   clock, asynchronous active-high reset
//   start                pulse: clear flags/counters, flush FIFO, capture
//   depth                original samples to capture (sampled on start)
//   rle_data, rle_valid  encoded word input (no backpressure)
//   dout, dout_valid     FIFO head word / not empty
//   dout_ready           consumer takes dout this cycle
//   sample_cnt           original samples accounted (saturating)
//   capture_done         high in DONE
//   overflow             sticky: a word was dropped on a full FIFO
//   fifo_level           [RLE_LEVEL_EN] FIFO word count
//   almost_full          [RLE_LEVEL_EN] fifo_level >= 2^ADDR_W - 8
// ---------------------------------------------------------------------------
module rle_buffer
  import rle_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 32
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] depth,
  input  logic [15:0]      rle_data,
  input  logic             rle_valid,
  output logic [15:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             capture_done,
  output logic             overflow
`ifdef RLE_LEVEL_EN
  ,
  output logic [ADDR_W:0]  fifo_level,
  output logic             almost_full
`endif
);

  rle_state_t       r_state;
  rle_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_depth;
  logic [CNT_W-1:0] r_sample_cnt;
  logic             r_overflow;
  logic             r_done;
  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;

  // One spare bit catches the carry so the counter can saturate.
  assign w_sum     = {1'b0, r_sample_cnt} + (CNT_W+1)'(rle_weight(rle_data));
  assign w_cnt_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (start) begin
      // Restart from any state; a zero depth has nothing to capture.
      w_state_nxt = (depth == '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (rle_valid) begin
            w_accept = 1'b1;
            if (w_cnt_nxt >= r_depth) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) w_state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state      <= ST_IDLE;
      r_depth      <= '0;
      r_sample_cnt <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      if (start) begin
        r_depth      <= depth;
        r_sample_cnt <= '0;
        r_overflow   <= 1'b0;
      end else if (w_accept) begin
        // Accounting applies even when the word itself is dropped.
        r_sample_cnt <= w_cnt_nxt;
        if (w_full && !(dout_ready && !w_empty)) r_overflow <= 1'b1;
      end
    end
  end

  rle_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_fifo (
    .clk           (core_clk),
    .rst           (core_rst),
    .i_flush       (start),
    .i_wr          (w_accept),
    .i_wdata       (rle_data),
    .i_rd          (dout_ready),
    .o_rdata       (dout),
    .o_empty       (w_empty),
    .o_full        (w_full)
`ifdef RLE_LEVEL_EN
    ,
    .o_level       (fifo_level),
    .o_almost_full (almost_full)
`endif
  );

  assign dout_valid   = ~w_empty;
  assign sample_cnt   = r_sample_cnt;
  assign capture_done = r_done;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_rle_buffer.sv
// ---------------------------------------------------------------------------
// tb_rle_buffer
// Directed testbench for rle_buffer, built with a 16-word FIFO (ADDR_W = 4).
// ---------------------------------------------------------------------------
module tb_rle_buffer;
  import rle_pkg::*;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 32;

  logic             core_clk = 1'b0;
  logic             core_rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] depth = '0;
  logic [15:0]      rle_data = '0;
  logic             rle_valid = 1'b0;
  logic [15:0]      dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic [CNT_W-1:0] sample_cnt;
  logic             capture_done;
  logic             overflow;
`ifdef RLE_LEVEL_EN
  logic [ADDR_W:0]  fifo_level;
  logic             almost_full;
`endif

  int total = 0;
  int bad   = 0;

  rle_buffer #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .start        (start),
    .depth        (depth),
    .rle_data     (rle_data),
    .rle_valid    (rle_valid),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .sample_cnt   (sample_cnt),
    .capture_done (capture_done),
    .overflow     (overflow)
`ifdef RLE_LEVEL_EN
    ,
    .fifo_level   (fifo_level),
    .almost_full  (almost_full)
`endif
  );

  always #5 core_clk = ~core_clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset, then reset mid-RUN with 5 words queued
    tick();
    tick();
    core_rst = 1'b0;
    start = 1'b1; depth = 100;
    tick();
    start = 1'b0;
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rle_valid = 1'b1; rle_data = 16'(i);
      tick();
    end
    rle_valid = 1'b0;
    chk("queued_cnt", sample_cnt, 5);
    chk("queued_head", 32'(dout), 'h0001);
    #2 core_rst = 1'b1;
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_capture_done", 32'(capture_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    core_rst = 1'b0;
    start = 1'b1; depth = 10;
    tick();
    start = 1'b0;
    tick();
    chk("restart_cnt", sample_cnt, 0);
    chk("restart_state", 32'(dut.r_state), 32'(ST_RUN));
    chk("restart_empty", 32'(dout_valid), 0);

    // ---------------- depth 4: 0003, 8002, 0005
    start = 1'b1; depth = 4;
    tick();
    start = 1'b0;
    dout_ready = 1'b1;
    rle_valid = 1'b1; rle_data = 16'h0003;
    tick();
    chk("b_cnt1", sample_cnt, 1);
    chk("b_dout1", 32'(dout), 'h0003);
    chk("b_state1", 32'(dut.r_state), 32'(ST_RUN));
    rle_data = 16'h8002;
    tick();
    chk("b_cnt2", sample_cnt, 3);
    chk("b_dout2", 32'(dout), 'h8002);
    chk("b_state2", 32'(dut.r_state), 32'(ST_RUN));
    rle_data = 16'h0005;
    tick();
    chk("b_cnt3", sample_cnt, 4);
    chk("b_dout3", 32'(dout), 'h0005);
    chk("b_state3", 32'(dut.r_state), 32'(ST_DRAIN));
    rle_valid = 1'b0;
    tick();
    chk("b_valid_after_read", 32'(dout_valid), 0);
    chk("b_done_early", 32'(capture_done), 0);
    tick();
    chk("b_done", 32'(capture_done), 1);
    chk("b_state_done", 32'(dut.r_state), 32'(ST_DONE));

    // ---------------- depth 100000 with overflow words
    start = 1'b1; depth = 100000;
    tick();
    start = 1'b0;
    chk("c_done_cleared", 32'(capture_done), 0);
    rle_valid = 1'b1; rle_data = 16'h0001;
    tick();
    chk("c_cnt1", sample_cnt, 1);
    rle_data = RLE_OVF_WORD;
    tick();
    chk("c_cnt2", sample_cnt, 32768);
    tick();
    chk("c_cnt3", sample_cnt, 65535);
    tick();
    chk("c_cnt4", sample_cnt, 98302);
    chk("c_done", 32'(capture_done), 0);
    chk("c_state", 32'(dut.r_state), 32'(ST_RUN));
    rle_valid = 1'b0;

    // ---------------- 17 writes into a 16-word FIFO, then read back
    start = 1'b1; depth = 1000;
    dout_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rle_valid = 1'b1; rle_data = 16'h0100 + 16'(i);
      tick();
    end
    chk("d_full", 32'(dut.w_full), 1);
    chk("d_ovf_before", 32'(overflow), 0);
    rle_data = 16'h01FF;
    tick();
    rle_valid = 1'b0;
    chk("d_ovf_after", 32'(overflow), 1);
    chk("d_cnt", sample_cnt, 17);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("d_read%0d", i), 32'(dout), 32'h0100 + 32'(i));
      tick();
    end
    chk("d_valid_fall", 32'(dout_valid), 0);
    chk("d_ovf_sticky", 32'(overflow), 1);

    // ---------------- full FIFO, write and read on the same edge
    start = 1'b1; depth = 1000;
    dout_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("e_ovf_cleared", 32'(overflow), 0);
    chk("e_flushed", 32'(dout_valid), 0);
    for (int i = 0; i < 16; i++) begin
      rle_valid = 1'b1; rle_data = 16'h0200 + 16'(i);
      tick();
    end
    chk("e_full", 32'(dut.w_full), 1);
    rle_data = 16'h0300; dout_ready = 1'b1;
    tick();
    rle_valid = 1'b0;
    chk("e_ovf", 32'(overflow), 0);
    chk("e_still_full", 32'(dut.w_full), 1);
    chk("e_head", 32'(dout), 'h0201);
    for (int i = 0; i < 15; i++) tick();
    chk("e_last_word", 32'(dout), 'h0300);
    chk("e_last_valid", 32'(dout_valid), 1);
    tick();
    chk("e_empty", 32'(dout_valid), 0);

    // ---------------- depth 0
    start = 1'b1; depth = 0;
    tick();
    start = 1'b0;
    chk("f_drain", 32'(dut.r_state), 32'(ST_DRAIN));
    chk("f_cnt0", sample_cnt, 0);
    rle_valid = 1'b1; rle_data = 16'h0007;
    tick();
    chk("f_done_state", 32'(dut.r_state), 32'(ST_DONE));
    chk("f_done", 32'(capture_done), 1);
    chk("f_cnt1", sample_cnt, 0);
    tick();
    rle_valid = 1'b0;
    chk("f_cnt2", sample_cnt, 0);
    chk("f_no_data", 32'(dout_valid), 0);
    start = 1'b1; depth = 5;
    tick();
    start = 1'b0;
    chk("f_rerun", 32'(dut.r_state), 32'(ST_RUN));
    chk("f_done_clr", 32'(capture_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
